uart_tx_core: RTL and testbench

UART transmitter, the counterpart of the UART receive path. It accepts a parallel byte with a one-cycle valid strobe and serialises it onto TX_OUT_tx:
- frame is start bit, 8 data bits LSB-first, optional parity bit, one stop bit
- one bit per clk_tx cycle; clk_tx is the TX baud clock, with no oversampling on the TX side
- sits beside the receiver in the UART top and is driven by the system-side data/config registers

---
 rtl/uart_pkg.sv | 21 ++
 rtl/serializer_tx.sv | 46 ++++
 rtl/uart_tx_core.sv | 108 ++++++++++
 tb/tb_uart_tx_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: encodings and defaults shared by the UART TX and RX paths.
// The FSM codes are Gray, so RX and TX state decodes stay identical.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_START  = 3'b001;
    localparam logic [2:0] ST_DATA   = 3'b011;
    localparam logic [2:0] ST_PARITY = 3'b010;
    localparam logic [2:0] ST_STOP   = 3'b110;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef struct packed {
        logic par_en;
        logic par_bit;
    } tx_cfg_t;

endpackage

// File: rtl/serializer_tx.sv
// serializer_tx: payload shift register and data-bit counter.
// ser_bit is the next bit to put on the line; ser_done marks the last one.
module serializer_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_tx,
    input  logic                  rst_tx,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  clear,
    input  logic                  count,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;

    always_ff @(posedge clk_tx) begin
        if (!rst_tx) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            if (load) begin
                shift_reg <= data_in;
            end else if (shift) begin
                shift_reg <= shift_reg >> 1;
            end
            if (clear) begin
                bit_cnt <= '0;
            end else if (count) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign ser_bit  = shift_reg[0];
    assign ser_done = count && (bit_cnt == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: start / data LSB-first / optional parity / stop framing.
// Line and busy are registered; each edge loads the level of the next cycle.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int   DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk_tx,
    input  logic                  rst_tx,
    input  logic [DATA_WIDTH-1:0] P_DATA_tx,
    input  logic                  Data_Valid_tx,
    input  logic                  PAR_EN_tx,
    input  logic                  PAR_TYP_tx,
    output logic                  TX_OUT_tx,
    output logic                  busy_tx
);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic       tx_nx;
    logic       busy_nx;
    tx_cfg_t    cfg;
    logic       accept;
    logic       ser_bit;
    logic       ser_done;
    logic       in_start;
    logic       in_data;

    assign accept   = (state == ST_IDLE) && Data_Valid_tx;
    assign in_start = (state == ST_START);
    assign in_data  = (state == ST_DATA);

    // Shifting starts while in START so the first data bit is ready in time.
    serializer_tx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk_tx   (clk_tx),
        .rst_tx   (rst_tx),
        .load     (accept),
        .shift    (in_start || in_data),
        .clear    (in_start),
        .count    (in_data),
        .data_in  (P_DATA_tx),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

    always_comb begin
        state_nx = ST_IDLE;
        tx_nx    = IDLE_LEVEL;
        busy_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Data_Valid_tx) begin
                    state_nx = ST_START;
                    tx_nx    = ~IDLE_LEVEL;
                    busy_nx  = 1'b1;
                end
            end
            ST_START: begin
                state_nx = ST_DATA;
                tx_nx    = ser_bit;
                busy_nx  = 1'b1;
            end
            ST_DATA: begin
                busy_nx = 1'b1;
                if (!ser_done) begin
                    state_nx = ST_DATA;
                    tx_nx    = ser_bit;
                end else if (cfg.par_en) begin
                    state_nx = ST_PARITY;
                    tx_nx    = cfg.par_bit;
                end else begin
                    state_nx = ST_STOP;
                end
            end
            ST_PARITY: begin
                state_nx = ST_STOP;
                busy_nx  = 1'b1;
            end
            ST_STOP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (!rst_tx) begin
            state     <= ST_IDLE;
            TX_OUT_tx <= IDLE_LEVEL;
            busy_tx   <= 1'b0;
            cfg       <= '0;
        end else begin
            state     <= state_nx;
            TX_OUT_tx <= tx_nx;
            busy_tx   <= busy_nx;
            if (accept) begin
                cfg.par_en  <= PAR_EN_tx;
                cfg.par_bit <= (^P_DATA_tx) ^ (PAR_TYP_tx != PAR_EVEN);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed frames with literal line patterns, then random
// traffic, all checked each cycle against a queue-based frame model.
module tb_uart_tx_core;

    logic       clk_tx;
    logic       rst_tx;
    logic [7:0] P_DATA_tx;
    logic       Data_Valid_tx;
    logic       PAR_EN_tx;
    logic       PAR_TYP_tx;
    logic       TX_OUT_tx;
    logic       busy_tx;

    int vectors;
    int miscompares;

    uart_tx_core dut (
        .clk_tx        (clk_tx),
        .rst_tx        (rst_tx),
        .P_DATA_tx     (P_DATA_tx),
        .Data_Valid_tx (Data_Valid_tx),
        .PAR_EN_tx     (PAR_EN_tx),
        .PAR_TYP_tx    (PAR_TYP_tx),
        .TX_OUT_tx     (TX_OUT_tx),
        .busy_tx       (busy_tx)
    );

    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    // Model: each accepted frame becomes a queue of {line, busy} per cycle.
    logic [1:0] q[$];
    logic       exp_tx;
    logic       exp_busy;
    bit         live;

    initial begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
        live     = 1'b0;
    end

    always @(posedge clk_tx) begin
        if (!rst_tx) begin
            q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            live     = 1'b1;
        end else if (live) begin
            if (!exp_busy && Data_Valid_tx) begin
                q.push_back(2'b01);
                for (int i = 0; i < 8; i++) begin
                    q.push_back({P_DATA_tx[i], 1'b1});
                end
                if (PAR_EN_tx) begin
                    q.push_back({1'(($countones(P_DATA_tx) + int'(PAR_TYP_tx)) % 2), 1'b1});
                end
                q.push_back(2'b11);
            end
            if (q.size() > 0) begin
                {exp_tx, exp_busy} = q.pop_front();
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    always @(negedge clk_tx) begin
        if (live) begin
            vectors++;
            if (TX_OUT_tx !== exp_tx || busy_tx !== exp_busy) begin
                miscompares++;
                $display("FAIL line t=%0t: tx=%b busy=%b expected tx=%b busy=%b",
                         $time, TX_OUT_tx, busy_tx, exp_tx, exp_busy);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [31:0] cap_tx;
    logic [31:0] cap_b;
    logic [31:0] mdl_tx;

    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA_tx     = d;
        PAR_EN_tx     = pe;
        PAR_TYP_tx    = pt;
        Data_Valid_tx = 1'b1;
        @(negedge clk_tx);
        Data_Valid_tx = 1'b0;
    endtask

    task automatic capture(input int n);
        cap_tx = '0;
        cap_b  = '0;
        mdl_tx = '0;
        for (int i = 0; i < n; i++) begin
            cap_tx[i] = TX_OUT_tx;
            cap_b[i]  = busy_tx;
            mdl_tx[i] = exp_tx;
            @(negedge clk_tx);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_tx        = 1'b0;
        Data_Valid_tx = 1'b0;
        P_DATA_tx     = '0;
        PAR_EN_tx     = 1'b0;
        PAR_TYP_tx    = 1'b0;
        repeat (3) @(negedge clk_tx);
        chk("reset_tx", 32'(TX_OUT_tx), 32'd1);
        chk("reset_busy", 32'(busy_tx), 32'd0);
        rst_tx = 1'b1;
        @(negedge clk_tx);

        start_frame(8'hA5, 1'b0, 1'b0);
        capture(11);
        chk("a5_tx", cap_tx, 32'b11101001010);
        chk("a5_busy", cap_b, 32'b01111111111);
        chk("a5_model", mdl_tx, 32'b11101001010);

        start_frame(8'hA5, 1'b1, 1'b0);
        capture(12);
        chk("a5_even_tx", cap_tx, 32'b110101001010);
        chk("a5_even_busy", cap_b, 32'b011111111111);
        chk("a5_even_model", mdl_tx, 32'b110101001010);

        start_frame(8'hA5, 1'b1, 1'b1);
        capture(12);
        chk("a5_odd_tx", cap_tx, 32'b111101001010);

        start_frame(8'h07, 1'b1, 1'b0);
        capture(12);
        chk("07_even_tx", cap_tx, 32'b111000001110);

        start_frame(8'h07, 1'b1, 1'b1);
        capture(12);
        chk("07_odd_tx", cap_tx, 32'b110000001110);
        chk("07_odd_busy", cap_b, 32'b011111111111);

        // Request during DATA must be dropped, not queued.
        start_frame(8'h3C, 1'b0, 1'b0);
        repeat (3) @(negedge clk_tx);
        P_DATA_tx     = 8'hFF;
        Data_Valid_tx = 1'b1;
        @(negedge clk_tx);
        Data_Valid_tx = 1'b0;
        repeat (6) @(negedge clk_tx);
        chk("ignore_busy10", 32'(busy_tx), 32'd0);
        @(negedge clk_tx);
        chk("ignore_busy11", 32'(busy_tx), 32'd0);
        chk("ignore_tx11", 32'(TX_OUT_tx), 32'd1);
        @(negedge clk_tx);

        start_frame(8'h96, 1'b1, 1'b1);
        P_DATA_tx  = 8'h69;
        PAR_EN_tx  = 1'b0;
        PAR_TYP_tx = 1'b0;
        capture(12);
        chk("stable_tx", cap_tx, 32'b111100101100);
        chk("stable_busy", cap_b, 32'b011111111111);

        P_DATA_tx     = 8'h55;
        PAR_EN_tx     = 1'b0;
        Data_Valid_tx = 1'b1;
        @(negedge clk_tx);
        P_DATA_tx = 8'hAA;
        capture(12);
        Data_Valid_tx = 1'b0;
        chk("b2b_tx", cap_tx, 32'b011010101010);
        chk("b2b_busy", cap_b, 32'b101111111111);
        repeat (11) @(negedge clk_tx);

        start_frame(8'h5A, 1'b0, 1'b0);
        repeat (5) @(negedge clk_tx);
        rst_tx = 1'b0;
        @(negedge clk_tx);
        chk("midrst_tx", 32'(TX_OUT_tx), 32'd1);
        chk("midrst_busy", 32'(busy_tx), 32'd0);
        rst_tx = 1'b1;
        @(negedge clk_tx);
        start_frame(8'h81, 1'b0, 1'b0);
        capture(11);
        chk("81_tx", cap_tx, 32'b11100000010);
        chk("81_busy", cap_b, 32'b01111111111);

        for (int i = 0; i < 600; i++) begin
            P_DATA_tx     = 8'($urandom);
            PAR_EN_tx     = 1'($urandom);
            PAR_TYP_tx    = 1'($urandom);
            Data_Valid_tx = ($urandom_range(0, 2) == 0);
            rst_tx        = ($urandom_range(0, 96) != 0);
            @(negedge clk_tx);
        end
        rst_tx        = 1'b1;
        Data_Valid_tx = 1'b0;
        repeat (14) @(negedge clk_tx);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
